// File: rtl/timer_multichannel.sv
// General-purpose timer: shared prescaled up-counter with CHANNELS compare units,
// each driving a toggle or PWM output, plus match/overflow flags and a level irq.
module timer_multichannel #(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned PRESCALER_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          bus_addr,
  input  logic                bus_wr,
  input  logic [31:0]         bus_wdata,
  input  logic                bus_rd,
  output logic [31:0]         bus_rdata,
  output logic [CHANNELS-1:0] cmp_out,
  output logic                irq
);

  localparam logic [3:0] A_CTRL     = 4'd0;
  localparam logic [3:0] A_PRESCALE = 4'd1;
  localparam logic [3:0] A_TOP      = 4'd2;
  localparam logic [3:0] A_COUNT    = 4'd3;
  localparam logic [3:0] A_STATUS   = 4'd4;
  localparam logic [3:0] A_IRQ_EN   = 4'd5;

  logic                       en_q, en_d, oneshot_q, oneshot_d, pwm_q, pwm_d;
  logic [PRESCALER_WIDTH-1:0] prescale_q, prescale_d, pre_cnt_q, pre_cnt_d;
  logic [WIDTH-1:0]           top_q, top_d, count_q, count_d;
  logic [CHANNELS-1:0]        match_q, match_d, ie_match_q, ie_match_d;
  logic [CHANNELS-1:0]        cmp_out_q, cmp_out_d;
  logic                       ovf_q, ovf_d, ie_ovf_q, ie_ovf_d;
  logic [WIDTH-1:0]           cmp_q [CHANNELS];
  logic [WIDTH-1:0]           cmp_d [CHANNELS];
  logic [31:0]                rdata_q, rdata_d, rd_val;

  logic wr_ctrl, wr_pre, wr_top, wr_count, wr_status, wr_ie;
  logic tick, tick_eff, wrap;
  logic [WIDTH-1:0] count_next;
  logic unused_wdata;

  assign wr_ctrl   = bus_wr && (bus_addr == A_CTRL);
  assign wr_pre    = bus_wr && (bus_addr == A_PRESCALE);
  assign wr_top    = bus_wr && (bus_addr == A_TOP);
  assign wr_count  = bus_wr && (bus_addr == A_COUNT);
  assign wr_status = bus_wr && (bus_addr == A_STATUS);
  assign wr_ie     = bus_wr && (bus_addr == A_IRQ_EN);

  assign tick       = en_q && (pre_cnt_q == prescale_q);
  // A COUNT write or an EN=0 write swallows the tick of that cycle.
  assign tick_eff   = tick && !wr_count && !(wr_ctrl && !bus_wdata[0]);
  assign wrap       = (count_q == top_q);
  assign count_next = wrap ? '0 : count_q + WIDTH'(1);

  assign unused_wdata = ^bus_wdata;

  always_comb begin
    en_d       = en_q;
    oneshot_d  = oneshot_q;
    pwm_d      = pwm_q;
    prescale_d = prescale_q;
    top_d      = top_q;
    count_d    = count_q;
    match_d    = match_q;
    ovf_d      = ovf_q;
    ie_match_d = ie_match_q;
    ie_ovf_d   = ie_ovf_q;
    cmp_out_d  = cmp_out_q;
    cmp_d      = cmp_q;
    pre_cnt_d  = (!en_q || tick) ? '0 : pre_cnt_q + PRESCALER_WIDTH'(1);

    if (wr_ctrl) begin
      {pwm_d, oneshot_d, en_d} = bus_wdata[2:0];
      if (!bus_wdata[0]) pre_cnt_d = '0;
    end
    if (wr_pre) prescale_d = bus_wdata[PRESCALER_WIDTH-1:0];
    if (wr_top) top_d = bus_wdata[WIDTH-1:0];
    if (wr_status) begin
      match_d = match_q & ~bus_wdata[CHANNELS-1:0];
      ovf_d   = ovf_q & ~bus_wdata[8];
    end
    if (wr_ie) begin
      ie_match_d = bus_wdata[CHANNELS-1:0];
      ie_ovf_d   = bus_wdata[8];
    end
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (bus_wr && (bus_addr == 4'(8 + i))) cmp_d[i] = bus_wdata[WIDTH-1:0];
    end

    if (wr_count) begin
      count_d   = bus_wdata[WIDTH-1:0];
      pre_cnt_d = '0;
    end else if (tick_eff) begin
      count_d = count_next;
      if (wrap) begin
        ovf_d = 1'b1;
        if (oneshot_q) en_d = 1'b0;
      end
      // Hardware set is applied after the W1C so it wins on collision.
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (count_next == cmp_q[i]) begin
          match_d[i] = 1'b1;
          if (!pwm_q) cmp_out_d[i] = ~cmp_out_q[i];
        end
      end
    end

    if (pwm_q) begin
      for (int unsigned i = 0; i < CHANNELS; i++) cmp_out_d[i] = (count_q < cmp_q[i]);
    end
  end

  always_comb begin
    rd_val = '0;
    case (bus_addr)
      A_CTRL:     rd_val = {29'd0, pwm_q, oneshot_q, en_q};
      A_PRESCALE: rd_val = 32'(prescale_q);
      A_TOP:      rd_val = 32'(top_q);
      A_COUNT:    rd_val = 32'(count_q);
      A_STATUS: begin
        rd_val[CHANNELS-1:0] = match_q;
        rd_val[8]            = ovf_q;
      end
      A_IRQ_EN: begin
        rd_val[CHANNELS-1:0] = ie_match_q;
        rd_val[8]            = ie_ovf_q;
      end
      default: begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          if (bus_addr == 4'(8 + i)) rd_val = 32'(cmp_q[i]);
        end
      end
    endcase
    rdata_d = bus_rd ? rd_val : rdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q       <= 1'b0;
      oneshot_q  <= 1'b0;
      pwm_q      <= 1'b0;
      prescale_q <= '0;
      pre_cnt_q  <= '0;
      top_q      <= '1;
      count_q    <= '0;
      match_q    <= '0;
      ovf_q      <= 1'b0;
      ie_match_q <= '0;
      ie_ovf_q   <= 1'b0;
      cmp_out_q  <= '0;
      rdata_q    <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) cmp_q[i] <= '0;
    end else begin
      en_q       <= en_d;
      oneshot_q  <= oneshot_d;
      pwm_q      <= pwm_d;
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
      top_q      <= top_d;
      count_q    <= count_d;
      match_q    <= match_d;
      ovf_q      <= ovf_d;
      ie_match_q <= ie_match_d;
      ie_ovf_q   <= ie_ovf_d;
      cmp_out_q  <= cmp_out_d;
      rdata_q    <= rdata_d;
      for (int unsigned i = 0; i < CHANNELS; i++) cmp_q[i] <= cmp_d[i];
    end
  end

  assign bus_rdata = rdata_q;
  assign cmp_out   = cmp_out_q;
  assign irq       = |({ovf_q, match_q} & {ie_ovf_q, ie_match_q});

endmodule
